// File: rtl/cell_truth_checker.sv
// Truth-table sweep checker for a small combinational cell: drives every input vector, samples ZN, counts mismatches.
// Optional build macro CELL_CHK_STOP_ON_FAIL_EN ends the sweep at the first mismatching vector.
module cell_truth_checker #(
  parameter int                     N_IN      = 3,
  parameter int                     SETTLE    = 10,
  parameter logic [(1<<N_IN)-1:0]   EXP_TABLE = 8'h07
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  output logic [N_IN-1:0] stim,
  input  logic            zn_in,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [N_IN:0]   err_count,
  output logic [N_IN-1:0] first_fail_vec,
  output logic            first_fail_valid
);

  localparam int              NVEC    = 1 << N_IN;
  localparam int              CNT_W   = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CNT_W-1:0] CNT_LD = CNT_W'(SETTLE - 1);
  localparam logic [N_IN:0]   ERR_MAX = (N_IN+1)'(NVEC);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_SAMPLE = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [N_IN-1:0]  r_stim;
  logic [N_IN:0]    r_err;
  logic [N_IN-1:0]  r_ff_vec;
  logic             r_ff_valid;
  logic             r_busy;
  logic             r_done;
  logic             r_pass;

  logic             w_exp;
  logic             w_mismatch;
  logic             w_last;
  logic             w_stop;
  logic             w_launch;
  logic             w_sample;
  logic [N_IN:0]    w_err_nxt;

  // X/Z on zn_in is treated as a mismatch in simulation
  assign w_exp      = EXP_TABLE[r_stim];
  assign w_mismatch = (zn_in !== w_exp);
  assign w_last     = (r_stim == {N_IN{1'b1}});

`ifdef CELL_CHK_STOP_ON_FAIL_EN
  assign w_stop = w_mismatch;
`else
  assign w_stop = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (start) w_state_nxt = S_SETTLE;
        else       w_state_nxt = r_state;
      end
      S_SETTLE: begin
        if (r_cnt == '0) w_state_nxt = S_SAMPLE;
        else             w_state_nxt = S_SETTLE;
      end
      S_SAMPLE: begin
        if (w_last || w_stop) w_state_nxt = S_DONE;
        else                  w_state_nxt = S_SETTLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Decoded controls and the saturating error update
  always_comb begin
    w_launch  = 1'b0;
    w_sample  = 1'b0;
    w_err_nxt = r_err;
    case (r_state)
      S_IDLE, S_DONE: w_launch = start;
      S_SAMPLE: begin
        w_sample = 1'b1;
        if (w_mismatch && (r_err != ERR_MAX)) w_err_nxt = r_err + {{N_IN{1'b0}}, 1'b1};
        else                                   w_err_nxt = r_err;
      end
      default: begin
        w_launch = 1'b0;
        w_sample = 1'b0;
      end
    endcase
  end

  // Sweep datapath and registered status outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt      <= '0;
      r_stim     <= '0;
      r_err      <= '0;
      r_ff_vec   <= '0;
      r_ff_valid <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_pass     <= 1'b0;
    end else if (w_launch) begin
      r_stim     <= '0;
      r_cnt      <= CNT_LD;
      r_err      <= '0;
      r_ff_valid <= 1'b0;
      r_busy     <= 1'b1;
      r_done     <= 1'b0;
      r_pass     <= 1'b0;
    end else if (r_state == S_SETTLE) begin
      if (r_cnt != '0) r_cnt <= r_cnt - {{(CNT_W-1){1'b0}}, 1'b1};
    end else if (w_sample) begin
      r_err <= w_err_nxt;
      if (w_mismatch && !r_ff_valid) begin
        r_ff_vec   <= r_stim;
        r_ff_valid <= 1'b1;
      end
      if (w_state_nxt == S_DONE) begin
        r_busy <= 1'b0;
        r_done <= 1'b1;
        r_pass <= (w_err_nxt == '0);
      end else begin
        r_stim <= r_stim + {{(N_IN-1){1'b0}}, 1'b1};
        r_cnt  <= CNT_LD;
      end
    end
  end

  assign stim             = r_stim;
  assign busy             = r_busy;
  assign done             = r_done;
  assign pass             = r_pass;
  assign err_count        = r_err;
  assign first_fail_vec   = r_ff_vec;
  assign first_fail_valid = r_ff_valid;

endmodule

// File: tb/tb_cell_truth_checker.sv
// Directed bench for cell_truth_checker with an AOI21 model and stuck-at cell outputs on zn_in.
// Edge numbering: the edge that samples start is edge 1.
module tb_cell_truth_checker;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [2:0] stim;
  logic       zn_in;
  logic       busy;
  logic       done;
  logic       pass;
  logic [3:0] err_count;
  logic [2:0] first_fail_vec;
  logic       first_fail_valid;

  int n_checks = 0;
  int n_errors = 0;
  int zn_mode  = 0;
  int done_edge;

`ifdef CELL_CHK_STOP_ON_FAIL_EN
  localparam int T0_EDGE = 12, T0_ERR = 1, T1_EDGE = 45, T1_ERR = 1, T1_STIM = 3, RST_MODE = 0, RST_ERR = 0;
`else
  localparam int T0_EDGE = 89, T0_ERR = 3, T1_EDGE = 89, T1_ERR = 5, T1_STIM = 7, RST_MODE = 1, RST_ERR = 3;
`endif

  cell_truth_checker dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .start            (start),
    .stim             (stim),
    .zn_in            (zn_in),
    .busy             (busy),
    .done             (done),
    .pass             (pass),
    .err_count        (err_count),
    .first_fail_vec   (first_fail_vec),
    .first_fail_valid (first_fail_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cell under test: 0 = good AOI21, 1 = stuck-at-0, 2 = stuck-at-1
  always_comb begin
    case (zn_mode)
      1:       zn_in = 1'b0;
      2:       zn_in = 1'b1;
      default: zn_in = ~(stim[2] | (stim[1] & stim[0]));
    endcase
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic launch();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("launch_busy", {31'd0, busy}, 32'd1);
    check("launch_done", {31'd0, done}, 32'd0);
    check("launch_stim", {29'd0, stim}, 32'd0);
    check("launch_err", {28'd0, err_count}, 32'd0);
    check("launch_ffvalid", {31'd0, first_fail_valid}, 32'd0);
  endtask

  // Counts edges from launch until done; optional start re-pulse sampled at edge poke_edge+1
  task automatic wait_done(input int poke_edge, output int edge_no);
    int n;
    n = 1;
    edge_no = 0;
    while (edge_no == 0 && n < 300) begin
      if (n == poke_edge) start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      n++;
      if (done) edge_no = n;
    end
    check("done_timeout", {31'd0, (edge_no != 0)}, 32'd1);
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    #23;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_pass", {31'd0, pass}, 32'd0);
    check("rst_stim", {29'd0, stim}, 32'd0);
    check("rst_err", {28'd0, err_count}, 32'd0);
    check("rst_ffvec", {29'd0, first_fail_vec}, 32'd0);
    check("rst_ffvalid", {31'd0, first_fail_valid}, 32'd0);
    rst_n = 1'b1;

    // Good cell
    zn_mode = 0;
    launch();
    wait_done(0, done_edge);
    check("good_edge", done_edge, 32'd89);
    check("good_err", {28'd0, err_count}, 32'd0);
    check("good_pass", {31'd0, pass}, 32'd1);
    check("good_ffvalid", {31'd0, first_fail_valid}, 32'd0);
    check("good_busy", {31'd0, busy}, 32'd0);
    repeat (5) @(posedge clk);
    #1;
    check("good_hold_done", {31'd0, done}, 32'd1);
    check("good_hold_err", {28'd0, err_count}, 32'd0);

    // Stuck-at-0: vectors 0,1,2 mismatch
    zn_mode = 1;
    launch();
    wait_done(0, done_edge);
    check("sa0_edge", done_edge, T0_EDGE);
    check("sa0_err", {28'd0, err_count}, T0_ERR);
    check("sa0_ffvec", {29'd0, first_fail_vec}, 32'd0);
    check("sa0_ffvalid", {31'd0, first_fail_valid}, 32'd1);
    check("sa0_pass", {31'd0, pass}, 32'd0);

    // Stuck-at-1: vectors 3..7 mismatch
    zn_mode = 2;
    launch();
    wait_done(0, done_edge);
    check("sa1_edge", done_edge, T1_EDGE);
    check("sa1_err", {28'd0, err_count}, T1_ERR);
    check("sa1_ffvec", {29'd0, first_fail_vec}, 32'd3);
    check("sa1_ffvalid", {31'd0, first_fail_valid}, 32'd1);
    check("sa1_pass", {31'd0, pass}, 32'd0);
    check("sa1_stim", {29'd0, stim}, T1_STIM);

    // Reset in the middle of vector 4
    zn_mode = RST_MODE;
    launch();
    repeat (49) @(posedge clk);
    #2;
    check("pre_rst_stim", {29'd0, stim}, 32'd4);
    check("pre_rst_busy", {31'd0, busy}, 32'd1);
    check("pre_rst_err", {28'd0, err_count}, RST_ERR);
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    check("mid_rst_stim", {29'd0, stim}, 32'd0);
    check("mid_rst_err", {28'd0, err_count}, 32'd0);
    check("mid_rst_ffvalid", {31'd0, first_fail_valid}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    zn_mode = 0;
    launch();
    wait_done(0, done_edge);
    check("post_rst_edge", done_edge, 32'd89);
    check("post_rst_pass", {31'd0, pass}, 32'd1);

    // Start re-pulsed during vector 2 must not restart the sweep
    launch();
    wait_done(25, done_edge);
    check("restart_edge", done_edge, 32'd89);
    check("restart_pass", {31'd0, pass}, 32'd1);
    check("restart_err", {28'd0, err_count}, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
